// File: rtl/hex_message_scroller.sv
// Purpose : holds a 16-nibble message and drives a scrolling 4-digit window (hex3 leftmost).
// Latency : pos/wrap update at the advancing edge; hex3..hex0 follow one cycle later.
// Backpres: none; the display driver consumes the outputs every cycle, writes are never stalled.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  absolute message slot write (independent of pos)
//   run                   1 = automatic scroll every PRESCALE cycles, 0 = paused
//   step                  manual single advance, only honoured while run = 0
//   dir                   0 = pos increments, 1 = pos decrements
//   hex3..hex0            window digits msg[pos..pos+3] (modulo 16)
//   pos                   current window start index
//   wrap                  one-cycle pulse after pos wraps 15->0 or 0->15
module hex_message_scroller #(
    parameter int PRESCALE = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       run,
    input  logic       step,
    input  logic       dir,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] pos,
    output logic       wrap
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       msg [16];
    logic [CNT_W-1:0] cnt;

    logic       advance;
    logic       at_wrap_edge;
    logic [3:0] pos_next;
    logic [3:0] idx1;
    logic [3:0] idx2;
    logic [3:0] idx3;

    always_comb begin
        // The prescaler is the only advance source while running; step only counts when paused.
        advance      = run ? (cnt == CNT_LAST) : step;
        pos_next     = dir ? (pos - 4'd1) : (pos + 4'd1);
        at_wrap_edge = dir ? (pos == 4'd0) : (pos == 4'd15);
        // 4-bit sums wrap naturally, giving the circular window.
        idx1         = pos + 4'd1;
        idx2         = pos + 4'd2;
        idx3         = pos + 4'd3;
    end

    // Message store: every slot has a reset value, so this stays in flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                msg[i] <= 4'(i);
            end
        end else if (wr_en) begin
            msg[wr_addr] <= wr_data;
        end
    end

    // Prescaler holds (not clears) while paused so a resume continues the interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == CNT_LAST) ? '0 : (cnt + CNT_ONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos  <= 4'd0;
            wrap <= 1'b0;
        end else begin
            wrap <= advance && at_wrap_edge;
            if (advance) begin
                pos <= pos_next;
            end
        end
    end

    // Window is sampled from pre-edge pos/msg, hence the one-cycle lag behind pos and writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex3 <= 4'd0;
            hex2 <= 4'd1;
            hex1 <= 4'd2;
            hex0 <= 4'd3;
        end else begin
            hex3 <= msg[pos];
            hex2 <= msg[idx1];
            hex1 <= msg[idx2];
            hex0 <= msg[idx3];
        end
    end

endmodule

// File: doc/hex_message_scroller.md
# hex_message_scroller

Upstream source for the four-digit LED driver. Holds a 16-nibble message and drives `hex3`..`hex0` with a four-digit window that steps through the message with wrap-around. Stepping is automatic at a prescaled rate, or manual one step at a time. Outputs connect directly to the driver's `hex3`..`hex0` inputs.

## Interface
- `PRESCALE`, default 50000000: clock cycles per automatic scroll step; must be ≥ 2.
- `CNT_W`, default 26: prescaler counter width; must satisfy 2^CNT_W ≥ PRESCALE.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  message write strobe.
- `wr_addr`  in  4  message slot to write.
- `wr_data`  in  4  nibble to write.
- `run`  in  1  level; 1 = automatic scrolling, 0 = paused.
- `step`  in  1  single-cycle pulse; manual advance, honoured only while `run`=0.
- `dir`  in  1  0 = pos increments (text moves left), 1 = pos decrements.
- `hex3`, `hex2`, `hex1`, `hex0`  out  4 each  window digits; `hex3` is the leftmost digit.
- `pos`  out  4  current window start index.
- `wrap`  out  1  one-cycle pulse on position wrap-around.

## Operation
- Storage: `msg[0..15]`, 4 bits each, held in flip-flops. Every slot is reset, so no inference to RAM.
- Write: when `wr_en`=1 at an edge, `msg[wr_addr]` <= `wr_data`. The address is absolute and does not depend on `pos`.
- Prescaler `cnt`:
  - While `run`=1, `cnt` increments each cycle.
  - At `cnt`=PRESCALE-1, `cnt` <= 0 and an advance occurs at that same edge.
  - While `run`=0, `cnt` holds its value and is not cleared. Resuming continues from the held count.
- Manual step: `step`=1 with `run`=0 causes an advance at that edge. `step` is ignored when `run`=1.
- Advance: `pos` <= `pos`+1 if `dir`=0, or `pos`-1 if `dir`=1, modulo 16. `dir` is sampled at the advancing edge. Changing `dir` between steps reverses direction at the next step.
- Window registers: at every edge, from the pre-edge `pos` and `msg` values:
  - `hex3` <= `msg[pos]`
  - `hex2` <= `msg[pos+1]`
  - `hex1` <= `msg[pos+2]`
  - `hex0` <= `msg[pos+3]`
  - All index arithmetic is 4-bit and wraps modulo 16.
- `wrap`: registered. It is 1 for exactly the cycle following an advance from 15→0 (`dir`=0) or 0→15 (`dir`=1), and 0 otherwise.
- Write and advance at the same edge: both take effect. Neither blocks the other.
- Reset (asserting `reset` clears state immediately, without waiting for `clk`):
  - `msg[i]` = i
  - `pos` = 0
  - `cnt` = 0
  - `hex3`/`hex2`/`hex1`/`hex0` = 0/1/2/3
  - `wrap` = 0
- Reset asserted mid-operation aborts any pending count. After `reset` deasserts, the next advance occurs PRESCALE `run` cycles later.

## Timing
- `pos` and `wrap` change at the advancing edge N.
- `hex*` reflect the new `pos` at edge N+1, i.e. one cycle of latency after `pos`.
- A write at edge N appears on the affected `hex*` output at edge N+1, if that slot is inside the window.
- Automatic advance period is exactly PRESCALE cycles of `run`=1.
- The first advance after reset with `run`=1 from cycle 0 occurs at the PRESCALE-th rising edge.
- `step` must be a one-cycle pulse. If held high, it advances once per cycle.

## Test plan
Benches use PRESCALE=4, `dir`=0 unless stated.
- **Reset values:** assert `reset` mid-cycle → outputs immediately show `hex3..0`=0,1,2,3, `pos`=0, `wrap`=0, with no clock edge required.
- **Automatic scroll:** `run`=1 → `pos` advances every 4 cycles; after the first advance, `hex3..0`=1,2,3,4 one cycle later. After 16 advances, `pos`=0, `wrap` is high for exactly one cycle, and `hex3..0`=0,1,2,3.
- **Window wrap:** with `pos`=14 → `hex3..0`=E,F,0,1.
- **Pause and step:**
  - `run`=1 for 2 cycles, then `run`=0 → `cnt` holds, no advance.
  - Pulse `step` → `pos`=1.
  - Set `run`=1 again → next advance occurs after 2 more cycles.
- **Reverse:** `dir`=1 with `pos`=0, pulse `step` → `pos`=F, `wrap` pulses for one cycle, `hex3..0`=F,0,1,2.
- **Write during scroll:** write `wr_addr`=2, `wr_data`=A at the same edge as an advance from `pos`=0 → `pos`=1, and the next cycle shows `hex3..0`=1,A,3,4.
